mips_regfile_mp: RTL and testbench

MIPS_REGFILE_MP -- requirements
Module: mips_regfile_mp

---
 rtl/mips_rf_pkg.sv | 19 +
 rtl/mips_rf_dump_ctrl.sv | 89 ++++++++
 rtl/mips_regfile_mp.sv | 97 +++++++++
 tb/tb_mips_regfile_mp.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_rf_pkg.sv
// Shared definitions for the multi-port MIPS register file.
// Holds the parameter defaults used by mips_regfile_mp and the
// dump controller, plus the dump state encoding.
package mips_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NRD_DEF    = 2;
  localparam int NWR_DEF    = 1;
  localparam int BYPASS_DEF = 1;

  // Dump controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/mips_rf_dump_ctrl.sv
// Dump sequencer for the register file.
// Walks an index from 0 to DEPTH-1, presenting one beat per index with a
// valid/ready handshake, then pulses dump_done for one cycle.
// Ports:
//   CLK, reset   - clock, synchronous active-high reset
//   dump_start   - one-cycle request, honoured only in IDLE
//   dump_ready   - consumer accepts the current beat
//   dump_valid   - beat valid (registered)
//   dump_addr    - current beat index (registered)
//   dump_busy    - high in DUMP and DONE (registered)
//   dump_done    - one-cycle pulse after the last beat (registered)
module mips_rf_dump_ctrl
  import mips_rf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          dump_start,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic          dump_busy,
  output logic          dump_done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  dump_state_t   state_r;
  logic [AW-1:0] index_r;
  logic          valid_r;
  logic          busy_r;
  logic          done_r;

  // State, beat index and handshake outputs advance together so every output is registered.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r <= IDLE;
      index_r <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (dump_start) begin
            state_r <= DUMP;
            index_r <= '0;
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        DUMP: begin
          // Beat accepted: move on, or finish after the last register.
          if (valid_r && dump_ready) begin
            if (index_r == LAST_IDX) begin
              state_r <= DONE;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              index_r <= index_r + AW'(1);
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          index_r <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          index_r <= '0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dump_valid = valid_r;
  assign dump_addr  = index_r;
  assign dump_busy  = busy_r;
  assign dump_done  = done_r;

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS-style register file with register 0 hardwired to zero,
// optional write-to-read forwarding, a 16-bit test tap and a streaming dump.
// Ports:
//   CLK, reset          - clock, synchronous active-high reset
//   RA / RD             - NRD combinational read ports (packed, port i at i*width)
//   WE / WA / WD        - NWR write ports, higher index wins on address clash
//   test_sel/test_value - low 16 bits of stored register test_sel
//   dump_*              - valid/ready stream of every register, see mips_rf_dump_ctrl
module mips_regfile_mp
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF,
  parameter int BYPASS = BYPASS_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     RA,
  output logic [NRD*DATA_W-1:0] RD,
  input  logic [NWR-1:0]        WE,
  input  logic [NWR*AW-1:0]     WA,
  input  logic [NWR*DATA_W-1:0] WD,
  input  logic [AW-1:0]         test_sel,
  output logic [15:0]           test_value,
  input  logic                  dump_start,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [AW-1:0]         dump_addr,
  output logic [DATA_W-1:0]     dump_data,
  output logic                  dump_busy,
  output logic                  dump_done
);

  localparam int TW = (DATA_W < 16) ? DATA_W : 16;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              dump_valid_s;
  logic [AW-1:0]     dump_idx_s;

  // Storage: later write ports are applied last, so the higher index wins a clash.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (WE[j] && (WA[j*AW +: AW] != '0)) begin
          mem_r[WA[j*AW +: AW]] <= WD[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read ports: address 0 reads zero; forwarding scans ports in ascending order so the highest matching writer wins.
  always_comb begin
    logic [AW-1:0]     ra_v;
    logic [DATA_W-1:0] rd_v;
    RD   = '0;
    ra_v = '0;
    rd_v = '0;
    for (int i = 0; i < NRD; i++) begin
      ra_v = RA[i*AW +: AW];
      rd_v = (ra_v == '0) ? '0 : mem_r[ra_v];
      for (int j = 0; j < NWR; j++) begin
        rd_v = ((BYPASS != 0) && WE[j] && (WA[j*AW +: AW] == ra_v) && (ra_v != '0))
               ? WD[j*DATA_W +: DATA_W] : rd_v;
      end
      RD[i*DATA_W +: DATA_W] = rd_v;
    end
  end

  // Test tap reads stored contents only; narrow registers are zero-extended.
  assign test_value = 16'(mem_r[test_sel][TW-1:0]);

  mips_rf_dump_ctrl #(
    .DEPTH(DEPTH)
  ) u_dump_ctrl (
    .CLK        (CLK),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid_s),
    .dump_addr  (dump_idx_s),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  // Beat data is read live from storage so an accepted beat shows that cycle's contents.
  assign dump_valid = dump_valid_s;
  assign dump_addr  = dump_idx_s;
  assign dump_data  = dump_valid_s ? mem_r[dump_idx_s] : '0;

endmodule

// File: tb/tb_mips_regfile_mp.sv
module tb_mips_regfile_mp;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  localparam logic [3:0] K_RD0 = 4'd0, K_RD1 = 4'd1, K_RD1NB = 4'd2, K_TV = 4'd3,
                         K_VALID = 4'd4, K_BUSY = 4'd5, K_DONE = 4'd6, K_ADDR = 4'd7,
                         K_DATA = 4'd8, K_DONECNT = 4'd9, K_RD0NB = 4'd10;

  typedef struct packed { logic [3:0] kind; logic [31:0] val; } chk_t;
  typedef struct packed { logic [4:0] addr; logic [31:0] data; } beat_t;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic [NRD*AW-1:0] RA = '0;
  logic [NRD*DW-1:0] RD, RD_nb;
  logic [NWR-1:0] WE = '0;
  logic [NWR*AW-1:0] WA = '0;
  logic [NWR*DW-1:0] WD = '0;
  logic [AW-1:0] test_sel = '0;
  logic [15:0] test_value, nb_test_value;
  logic dump_start = 1'b0, dump_ready = 1'b0;
  logic dump_valid, dump_busy, dump_done;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic nb_dump_valid, nb_dump_busy, nb_dump_done;
  logic [AW-1:0] nb_dump_addr;
  logic [DW-1:0] nb_dump_data;

  chk_t imm_q[$];
  beat_t beat_q[$];
  logic [31:0] model[32];
  int checks = 0, errors = 0;
  int beats_seen = 0, done_cnt = 0;
  logic hold_prev = 1'b0;
  logic [AW-1:0] held_addr = '0;

  mips_regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .CLK(CLK), .reset(reset), .RA(RA), .RD(RD), .WE(WE), .WA(WA), .WD(WD),
    .test_sel(test_sel), .test_value(test_value), .dump_start(dump_start),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done));

  mips_regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
    .CLK(CLK), .reset(reset), .RA(RA), .RD(RD_nb), .WE(WE), .WA(WA), .WD(WD),
    .test_sel(test_sel), .test_value(nb_test_value), .dump_start(dump_start),
    .dump_valid(nb_dump_valid), .dump_ready(dump_ready), .dump_addr(nb_dump_addr),
    .dump_data(nb_dump_data), .dump_busy(nb_dump_busy), .dump_done(nb_dump_done));

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic string kname(input logic [3:0] k);
    case (k)
      K_RD0: return "rd0";
      K_RD1: return "rd1";
      K_RD1NB: return "rd1_nobypass";
      K_RD0NB: return "rd0_nobypass";
      K_TV: return "test_value";
      K_VALID: return "dump_valid";
      K_BUSY: return "dump_busy";
      K_DONE: return "dump_done";
      K_ADDR: return "dump_addr";
      K_DATA: return "dump_data";
      K_DONECNT: return "dump_done_count";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual(input logic [3:0] k);
    case (k)
      K_RD0: return RD[31:0];
      K_RD1: return RD[63:32];
      K_RD1NB: return RD_nb[63:32];
      K_RD0NB: return RD_nb[31:0];
      K_TV: return {16'h0, test_value};
      K_VALID: return {31'h0, dump_valid};
      K_BUSY: return {31'h0, dump_busy};
      K_DONE: return {31'h0, dump_done};
      K_ADDR: return {27'h0, dump_addr};
      K_DATA: return dump_data;
      K_DONECNT: return 32'(done_cnt);
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  task automatic expect_out(input logic [3:0] k, input logic [31:0] v);
    chk_t c;
    c.kind = k;
    c.val = v;
    imm_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_wr(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
    WE = we;
    WA = {a1, a0};
    WD = {d1, d0};
    if (we[0] && a0 != 5'd0) model[a0] = d0;
    if (we[1] && a1 != 5'd0) model[a1] = d1;
  endtask

  task automatic push_all_beats();
    beat_t b;
    for (int k = 0; k < 32; k++) begin
      b.addr = 5'(k);
      b.data = model[k];
      beat_q.push_back(b);
    end
  endtask

  // Monitor: consumes queued expectations and every accepted dump beat.
  always @(negedge CLK) begin : monitor
    chk_t c;
    beat_t b;
    if (dump_done === 1'b1) done_cnt++;
    while (imm_q.size() != 0) begin
      c = imm_q.pop_front();
      check(kname(c.kind), actual(c.kind), c.val);
    end
    if (hold_prev) begin
      check("hold_valid", {31'h0, dump_valid}, 32'd1);
      check("hold_addr", {27'h0, dump_addr}, {27'h0, held_addr});
    end
    if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
      beats_seen++;
      if (beat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected actual addr=%0d expected no beat", dump_addr);
      end else begin
        b = beat_q.pop_front();
        check("beat_addr", {27'h0, dump_addr}, {27'h0, b.addr});
        check("beat_data", dump_data, b.data);
      end
    end
    hold_prev = (dump_valid === 1'b1) && (dump_ready === 1'b0) && (reset === 1'b0);
    held_addr = dump_addr;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    int done_before;
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    // Reset state
    RA = {5'd9, 5'd3};
    test_sel = 5'd5;
    expect_out(K_RD0, 32'h0); expect_out(K_RD1, 32'h0); expect_out(K_TV, 32'h0);
    expect_out(K_VALID, 32'h0); expect_out(K_BUSY, 32'h0); expect_out(K_DONE, 32'h0);
    expect_out(K_ADDR, 32'h0); expect_out(K_DATA, 32'h0);
    tick();
    // Basic write then read, test tap, duplicate read addresses
    drive_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    tick();
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    RA = {5'd5, 5'd5};
    expect_out(K_RD0, 32'hDEADBEEF); expect_out(K_RD1, 32'hDEADBEEF); expect_out(K_TV, 32'h0000BEEF);
    tick();
    // Writes to register 0 are discarded, never forwarded
    drive_wr(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0);
    RA = {5'd0, 5'd0};
    expect_out(K_RD0, 32'h0); expect_out(K_RD1, 32'h0);
    tick();
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    test_sel = 5'd0;
    expect_out(K_RD0, 32'h0); expect_out(K_TV, 32'h0);
    tick();
    // Forwarding vs pre-write contents
    drive_wr(2'b01, 5'd7, 32'h11111111, 5'd0, 32'h0);
    tick();
    drive_wr(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0);
    RA = {5'd7, 5'd5};
    expect_out(K_RD1, 32'hA5A5A5A5); expect_out(K_RD1NB, 32'h11111111);
    tick();
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    expect_out(K_RD1, 32'hA5A5A5A5); expect_out(K_RD1NB, 32'hA5A5A5A5);
    tick();
    // Both ports hit register 3: port 1 wins, also on the forwarding path
    drive_wr(2'b11, 5'd3, 32'h11, 5'd3, 32'h22);
    RA = {5'd3, 5'd3};
    expect_out(K_RD0, 32'h22); expect_out(K_RD0NB, 32'h0);
    tick();
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    test_sel = 5'd3;
    expect_out(K_RD0, 32'h22); expect_out(K_RD1NB, 32'h22); expect_out(K_TV, 32'h22);
    tick();
    // Preload reg k = k*0x10
    for (int k = 0; k < 32; k += 2) begin
      drive_wr(2'b11, 5'(k), 32'(k * 16), 5'(k + 1), 32'((k + 1) * 16));
      tick();
    end
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    RA = {5'd31, 5'd16};
    expect_out(K_RD0, 32'h100); expect_out(K_RD1, 32'h1F0);
    tick();
    // Full dump with toggling ready, a write mid-dump and an ignored restart
    dump_start = 1'b1;
    dump_ready = 1'b0;
    tick();
    dump_start = 1'b0;
    drive_wr(2'b10, 5'd0, 32'h0, 5'd20, 32'hCAFE0020);
    push_all_beats();
    expect_out(K_VALID, 32'd1); expect_out(K_BUSY, 32'd1); expect_out(K_ADDR, 32'd0);
    for (int cyc = 0; cyc < 300 && beat_q.size() != 0; cyc++) begin
      tick();
      drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      dump_ready = ~dump_ready;
      dump_start = (cyc == 6);
    end
    dump_start = 1'b0;
    checks++;
    if (beat_q.size() != 0) begin
      errors++;
      $display("FAIL dump_beats_left actual=%0d expected=0", beat_q.size());
    end
    dump_ready = 1'b0;
    expect_out(K_DONE, 32'd1); expect_out(K_BUSY, 32'd1); expect_out(K_VALID, 32'd0);
    tick();
    expect_out(K_DONE, 32'd0); expect_out(K_BUSY, 32'd0); expect_out(K_VALID, 32'd0);
    tick();
    expect_out(K_DONECNT, 32'd1);
    tick();
    // Reset in the middle of a dump
    done_before = done_cnt;
    dump_start = 1'b1;
    dump_ready = 1'b1;
    tick();
    dump_start = 1'b0;
    push_all_beats();
    base = beats_seen;
    for (int n = 0; n < 100 && (beats_seen - base) < 10; n++) tick();
    checks++;
    if ((beats_seen - base) != 10) begin
      errors++;
      $display("FAIL dump_progress actual=%0d expected=10", beats_seen - base);
    end
    reset = 1'b1;
    dump_ready = 1'b0;
    tick();
    reset = 1'b0;
    beat_q.delete();
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    expect_out(K_VALID, 32'd0); expect_out(K_BUSY, 32'd0); expect_out(K_DONE, 32'd0);
    expect_out(K_ADDR, 32'd0); expect_out(K_DATA, 32'd0);
    tick();
    for (int a = 0; a < 32; a += 2) begin
      RA = {5'(a + 1), 5'(a)};
      test_sel = 5'(a + 1);
      expect_out(K_RD0, 32'h0); expect_out(K_RD1, 32'h0); expect_out(K_TV, 32'h0);
      tick();
    end
    expect_out(K_DONECNT, 32'(done_before));
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
